sess_acc_arb: RTL and testbench

Session-flag access scheduler for the 6C tag digital core. Serialises session-flag store accesses from three requesters: power-up restore, command-parser reads and inventory-handler writes. Drives the store's read strobe and its S1/SX update strobes with a shared address and write data. Enforces fixed store latency between accesses and returns per-requester grant/done pulses.

---
 rtl/sess_pkg.sv | 29 ++
 rtl/sess_decay_tmr.sv | 32 +++
 rtl/sess_acc_arb.sv | 158 +++++++++++++++
 tb/tb_sess_acc_arb.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sess_pkg.sv
// Shared types and constants for the session-flag access scheduler.
package sess_pkg;

  localparam int LAT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_WAIT  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OWN_INIT  = 2'd0,
    OWN_RD    = 2'd1,
    OWN_WR    = 2'd2,
    OWN_DECAY = 2'd3
  } owner_t;

  localparam logic [1:0] SESS_S0 = 2'b00;
  localparam logic [1:0] SESS_S1 = 2'b01;
  localparam logic [1:0] SESS_S2 = 2'b10;
  localparam logic [1:0] SESS_S3 = 2'b11;

  // The store keeps the decaying S1 flag behind address 00, hence S1UPD there.
  localparam logic [1:0] S1_FLAG_ADDR = SESS_S0;

endpackage

// File: rtl/sess_decay_tmr.sv
// S1 decay timer: free-running period counter plus a single pending flag.
module sess_decay_tmr #(
  parameter int DECAY_CYC = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold,
  input  logic clr,
  output logic pend
);

  localparam int CW = $clog2(DECAY_CYC);

  logic [CW-1:0] cnt;
  logic          tc;

  assign tc = (cnt == CW'(DECAY_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      pend <= 1'b0;
    end else begin
      if (hold || tc) cnt <= '0;
      else            cnt <= cnt + 1'b1;
      // A terminal count while already pending just re-asserts the one flag.
      if (tc && !hold) pend <= 1'b1;
      else if (clr)    pend <= 1'b0;
    end
  end

endmodule

// File: rtl/sess_acc_arb.sv
// Session-flag store access scheduler. Optional S1 decay: define SESS_S1_DECAY_EN.
module sess_acc_arb
  import sess_pkg::*;
#(
  parameter int LAT       = 2,
  parameter int DECAY_CYC = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init_req,
  input  logic       rd_req,
  input  logic [1:0] rd_addr,
  input  logic       wr_req,
  input  logic [1:0] wr_addr,
  input  logic       wr_data,
  output logic       init_gnt,
  output logic       rd_gnt,
  output logic       wr_gnt,
  output logic       init_done,
  output logic       rd_done,
  output logic       wr_done,
  output logic       SRD,
  output logic       S1UPD,
  output logic       SXUPD,
  output logic [1:0] SADDR,
  output logic       SWDATA,
  output logic       busy
);

  state_t             state;
  owner_t             owner;
  logic [LAT_W-1:0]   cnt;
  logic               decay_pend;
  logic               fire_done;

  // Done is registered, so it is launched one cycle before the counter reads 1.
  assign fire_done = ((state == ST_WAIT) && (cnt == LAT_W'(2))) ||
                     ((state inside {ST_INIT, ST_READ, ST_WRITE}) && (LAT == 1));

`ifdef SESS_S1_DECAY_EN
  logic init_active;
  logic decay_clr;

  assign init_active = busy && (owner == OWN_INIT);
  assign decay_clr   = (state == ST_IDLE) && !init_req && decay_pend;

  sess_decay_tmr #(
    .DECAY_CYC (DECAY_CYC)
  ) u_decay (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (init_active),
    .clr   (decay_clr),
    .pend  (decay_pend)
  );
`else
  // Without decay support DECAY_CYC has no effect; the term folds to zero.
  assign decay_pend = 1'b0 & (DECAY_CYC > 0);
`endif

  // NOTE: every register here uses <= so all branches see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      owner     <= OWN_INIT;
      cnt       <= '0;
      init_gnt  <= 1'b0;
      rd_gnt    <= 1'b0;
      wr_gnt    <= 1'b0;
      init_done <= 1'b0;
      rd_done   <= 1'b0;
      wr_done   <= 1'b0;
      SRD       <= 1'b0;
      S1UPD     <= 1'b0;
      SXUPD     <= 1'b0;
      SADDR     <= SESS_S0;
      SWDATA    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      init_gnt  <= 1'b0;
      rd_gnt    <= 1'b0;
      wr_gnt    <= 1'b0;
      init_done <= 1'b0;
      rd_done   <= 1'b0;
      wr_done   <= 1'b0;
      SRD       <= 1'b0;
      S1UPD     <= 1'b0;
      SXUPD     <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (init_req) begin
            state    <= ST_INIT;
            owner    <= OWN_INIT;
            init_gnt <= 1'b1;
            SRD      <= 1'b1;
            SADDR    <= SESS_S0;
            busy     <= 1'b1;
          end else if (decay_pend) begin
            state  <= ST_WRITE;
            owner  <= OWN_DECAY;
            S1UPD  <= 1'b1;
            SADDR  <= S1_FLAG_ADDR;
            SWDATA <= 1'b0;
            busy   <= 1'b1;
          end else if (wr_req) begin
            state  <= ST_WRITE;
            owner  <= OWN_WR;
            wr_gnt <= 1'b1;
            S1UPD  <= (wr_addr == S1_FLAG_ADDR);
            SXUPD  <= (wr_addr != S1_FLAG_ADDR);
            SADDR  <= wr_addr;
            SWDATA <= wr_data;
            busy   <= 1'b1;
          end else if (rd_req) begin
            state  <= ST_READ;
            owner  <= OWN_RD;
            rd_gnt <= 1'b1;
            SRD    <= 1'b1;
            SADDR  <= rd_addr;
            busy   <= 1'b1;
          end
        end

        ST_INIT, ST_READ, ST_WRITE: begin
          state <= ST_WAIT;
          cnt   <= LAT_W'(LAT);
        end

        ST_WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == LAT_W'(1)) begin
            if ((owner == OWN_INIT) && (SADDR != SESS_S3)) begin
              state <= ST_INIT;
              SRD   <= 1'b1;
              SADDR <= SADDR + 2'd1;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (fire_done) begin
        init_done <= (owner == OWN_INIT) && (SADDR == SESS_S3);
        rd_done   <= (owner == OWN_RD);
        wr_done   <= (owner == OWN_WR);
      end
    end
  end

endmodule

// File: tb/tb_sess_acc_arb.sv
// Self-checking bench for sess_acc_arb: transaction-level scheduler model vs cycle outputs.
module tb_sess_acc_arb;

  localparam int LAT       = 2;
  localparam int DECAY_CYC = 16;
  localparam int MAXW      = 160;

  localparam int K_INIT = 0;
  localparam int K_RD   = 1;
  localparam int K_WR   = 2;

  // Bit positions of the packed control vector.
  localparam int B_IGNT = 9, B_RGNT = 8, B_WGNT = 7, B_IDONE = 6, B_RDONE = 5;
  localparam int B_WDONE = 4, B_SRD = 3, B_S1 = 2, B_SX = 1, B_BUSY = 0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       init_req, rd_req, wr_req, wr_data;
  logic [1:0] rd_addr, wr_addr;
  logic       init_gnt, rd_gnt, wr_gnt, init_done, rd_done, wr_done;
  logic       SRD, S1UPD, SXUPD, SWDATA, busy;
  logic [1:0] SADDR;

  always #5 clk = ~clk;

  sess_acc_arb #(
    .LAT       (LAT),
    .DECAY_CYC (DECAY_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_req  (init_req),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .init_gnt  (init_gnt),
    .rd_gnt    (rd_gnt),
    .wr_gnt    (wr_gnt),
    .init_done (init_done),
    .rd_done   (rd_done),
    .wr_done   (wr_done),
    .SRD       (SRD),
    .S1UPD     (S1UPD),
    .SXUPD     (SXUPD),
    .SADDR     (SADDR),
    .SWDATA    (SWDATA),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_ctl  [0:MAXW];
  logic [1:0] exp_addr [0:MAXW];
  logic       exp_wd   [0:MAXW];
  bit         chk_addr [0:MAXW];
  bit         chk_wd   [0:MAXW];

  int         r_at   [3];
  logic [1:0] r_addr [3];
  logic       r_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] ctl();
    return {init_gnt, rd_gnt, wr_gnt, init_done, rd_done, wr_done, SRD, S1UPD, SXUPD, busy};
  endfunction

  task automatic clear_reqs();
    for (int k = 0; k < 3; k++) begin
      r_at[k]   = -1;
      r_addr[k] = 2'b00;
    end
    r_data = 1'b0;
  endtask

  task automatic set_req(input int kind, input int at, input logic [1:0] addr, input logic data);
    r_at[kind]   = at;
    r_addr[kind] = addr;
    if (kind == K_WR) r_data = data;
  endtask

  // Paints one access of the given kind, granted in cycle 'start', into the expectation arrays.
  function automatic void add_access(input int kind, input int start, input logic [1:0] addr,
                                     input logic data);
    if (kind == K_INIT) begin
      exp_ctl[start][B_IGNT] = 1'b1;
      for (int k = 0; k < 4; k++) begin
        int s = start + k * (LAT + 1);
        exp_ctl[s][B_SRD] = 1'b1;
        for (int j = 0; j <= LAT; j++) begin
          exp_ctl[s + j][B_BUSY] = 1'b1;
          exp_addr[s + j]        = 2'(k);
          chk_addr[s + j]        = 1'b1;
        end
      end
      exp_ctl[start + 4 * (LAT + 1) - 1][B_IDONE] = 1'b1;
    end else begin
      if (kind == K_RD) begin
        exp_ctl[start][B_RGNT]      = 1'b1;
        exp_ctl[start][B_SRD]       = 1'b1;
        exp_ctl[start + LAT][B_RDONE] = 1'b1;
      end else begin
        exp_ctl[start][B_WGNT]      = 1'b1;
        exp_ctl[start][(addr == 2'b00) ? B_S1 : B_SX] = 1'b1;
        exp_ctl[start + LAT][B_WDONE] = 1'b1;
      end
      for (int j = 0; j <= LAT; j++) begin
        exp_ctl[start + j][B_BUSY] = 1'b1;
        exp_addr[start + j]        = addr;
        chk_addr[start + j]        = 1'b1;
        if (kind == K_WR) begin
          exp_wd[start + j] = data;
          chk_wd[start + j] = 1'b1;
        end
      end
    end
  endfunction

  // Serves pending requests in priority order whenever the arbiter is free; returns the idle cycle.
  function automatic int model();
    bit pend [3];
    int t = 0;
    for (int i = 0; i <= MAXW; i++) begin
      exp_ctl[i] = '0; exp_addr[i] = '0; exp_wd[i] = 1'b0;
      chk_addr[i] = 1'b0; chk_wd[i] = 1'b0;
    end
    for (int k = 0; k < 3; k++) pend[k] = (r_at[k] >= 0);
    while (pend[K_INIT] || pend[K_RD] || pend[K_WR]) begin
      int ts = MAXW;
      int pick = -1;
      for (int k = 0; k < 3; k++) if (pend[k] && r_at[k] < ts) ts = r_at[k];
      if (ts < t) ts = t;
      if (pend[K_INIT] && r_at[K_INIT] <= ts)    pick = K_INIT;
      else if (pend[K_WR] && r_at[K_WR] <= ts)   pick = K_WR;
      else                                       pick = K_RD;
      add_access(pick, ts + 1, r_addr[pick], r_data);
      t = ts + 1 + ((pick == K_INIT) ? 4 * (LAT + 1) : (LAT + 1));
      pend[pick] = 1'b0;
    end
    return t;
  endfunction

  // Drives the requests described by r_at/r_addr and compares every cycle up to the idle cycle.
  task automatic run_window(input string name);
    int last = model();
    for (int c = 0; c <= last; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        check($sformatf("%s ctl c%0d", name, c), 32'(ctl()), 32'(exp_ctl[c]));
        if (chk_addr[c]) check($sformatf("%s SADDR c%0d", name, c), 32'(SADDR), 32'(exp_addr[c]));
        if (chk_wd[c])   check($sformatf("%s SWDATA c%0d", name, c), 32'(SWDATA), 32'(exp_wd[c]));
        if (init_gnt) init_req = 1'b0;
        if (rd_gnt) begin
          rd_req  = 1'b0;
          rd_addr = 2'($urandom_range(0, 3));
        end
        if (wr_gnt) begin
          wr_req  = 1'b0;
          wr_addr = 2'($urandom_range(0, 3));
          wr_data = 1'($urandom_range(0, 1));
        end
      end
      if (r_at[K_INIT] == c) init_req = 1'b1;
      if (r_at[K_RD] == c) begin
        rd_req  = 1'b1;
        rd_addr = r_addr[K_RD];
      end
      if (r_at[K_WR] == c) begin
        wr_req  = 1'b1;
        wr_addr = r_addr[K_WR];
        wr_data = r_data;
      end
    end
    check($sformatf("%s drained", name), 32'({init_req, rd_req, wr_req}), 32'(0));
    init_req = 1'b0;
    rd_req   = 1'b0;
    wr_req   = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n    = 1'b0;
    init_req = 1'b0;
    rd_req   = 1'b0;
    wr_req   = 1'b0;
    rd_addr  = 2'b00;
    wr_addr  = 2'b00;
    wr_data  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("in_reset ctl", 32'(ctl()), 32'(0));
    rst_n = 1'b1;
    #1;
    check("reset ctl", 32'(ctl()), 32'(0));
    check("reset SADDR", 32'(SADDR), 32'(0));
    check("reset SWDATA", 32'(SWDATA), 32'(0));

    clear_reqs();
    set_req(K_INIT, 0, 2'b00, 1'b0);
    run_window("init");

`ifdef SESS_S1_DECAY_EN
    begin
      int last_decay = -1;
      int n_decay    = 0;
      rst_n   = 1'b0;
      wr_req  = 1'b1;
      wr_addr = 2'b01;
      wr_data = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int c = 1; c <= 96; c++) begin
        @(posedge clk); #1;
        if (S1UPD) begin
          check("decay no_gnt", 32'(wr_gnt), 32'(0));
          check("decay SADDR", 32'(SADDR), 32'(0));
          check("decay SWDATA", 32'(SWDATA), 32'(0));
          if (last_decay >= 0) check("decay interval", 32'(c - last_decay), 32'(DECAY_CYC));
          last_decay = c;
          n_decay++;
        end
      end
      check("decay count", 32'(n_decay), 32'(5));
      wr_req = 1'b0;
      repeat (LAT + 3) @(posedge clk);
      #1;
    end
`else
    clear_reqs();
    set_req(K_WR, 0, 2'b00, 1'b1);
    run_window("wr_s1");

    clear_reqs();
    set_req(K_WR, 0, 2'b10, 1'b0);
    run_window("wr_sx");

    clear_reqs();
    set_req(K_RD, 0, 2'b11, 1'b0);
    run_window("rd_s3");

    clear_reqs();
    set_req(K_RD, 0, 2'b01, 1'b0);
    set_req(K_WR, 0, 2'b11, 1'b1);
    run_window("rd_wr_same");

    for (int it = 0; it < 30; it++) begin
      int mode = int'($urandom_range(0, 5));
      logic [1:0] ra = 2'($urandom_range(0, 3));
      logic [1:0] wa = 2'($urandom_range(0, 3));
      logic       wd = 1'($urandom_range(0, 1));
      clear_reqs();
      case (mode)
        0: set_req(K_RD, 0, ra, 1'b0);
        1: set_req(K_WR, 0, wa, wd);
        2: begin set_req(K_RD, 0, ra, 1'b0); set_req(K_WR, 0, wa, wd); end
        3: begin set_req(K_INIT, 0, 2'b00, 1'b0); set_req(K_RD, 0, ra, 1'b0); end
        4: begin set_req(K_WR, 0, wa, wd); set_req(K_RD, 2, ra, 1'b0); end
        default: begin set_req(K_RD, 0, ra, 1'b0); set_req(K_WR, 1, wa, wd); end
      endcase
      run_window($sformatf("rnd%0d_m%0d", it, mode));
    end

    // Reset during the WAIT of a read; the read stays requested across reset.
    rd_req  = 1'b1;
    rd_addr = 2'b01;
    @(posedge clk); #1;
    check("rst rd_gnt", 32'(rd_gnt), 32'(1));
    @(posedge clk); #1;
    check("rst busy_pre", 32'(busy), 32'(1));
    check("rst done_pre", 32'(rd_done), 32'(0));
    #3 rst_n = 1'b0;
    #1;
    check("rst async ctl", 32'(ctl()), 32'(0));
    check("rst async SADDR", 32'(SADDR), 32'(0));
    check("rst async SWDATA", 32'(SWDATA), 32'(0));
    repeat (2) begin
      @(posedge clk); #1;
      check("rst no_done", 32'(rd_done), 32'(0));
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_reqs();
    set_req(K_RD, 0, 2'b01, 1'b0);
    run_window("rst_rerun");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
